// File: rtl/spi_mosi_burst_tx.sv
// -----------------------------------------------------------------------------
// spi_mosi_burst_tx
//
// SPI MOSI burst transmitter for the SSD1331 OLED path. A single start cycle
// captures up to DEPTH words of WIDTH bits plus one D/C flag per word. The
// requested number of words is then shifted out on o_MOSI, with o_CS and o_DC
// framing each word.
//
// Optional build macro:
//   MOSI_LSB_FIRST_EN - when defined, each word is shifted LSB first.
//                       When undefined (default), each word is shifted MSB first.
//                       Framing, timing and handshakes are identical in both builds.
//
// Parameters:
//   WIDTH  - bits per word
//   DEPTH  - maximum words captured per burst
//   CNT_W  - width of i_N_transmit (2^CNT_W-1 >= DEPTH)
//   CS_GAP - CS-high idle cycles between consecutive words (0 = CS held low)
//
// Ports:
//   i_SCK         clock; all state changes on the rising edge
//   i_RST         synchronous active-high reset
//   i_START       burst request, sampled every rising edge
//   i_N_transmit  number of words for this burst (clamped to DEPTH)
//   i_DATA        word k at [k*WIDTH +: WIDTH]; word 0 is sent first
//   i_DC          D/C flag for word k at bit k
//   o_MOSI        serial data
//   o_CS          chip select, active low
//   o_DC          D/C flag of the word currently on o_MOSI
//   o_BUSY        burst in progress
//   o_BYTE_DONE   one-cycle pulse per completed word
//   o_DONE        one-cycle pulse at burst end
//   o_REJECT      one-cycle pulse when i_START arrives during a burst
// -----------------------------------------------------------------------------
module spi_mosi_burst_tx #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4,
    parameter int CS_GAP = 1
) (
    input  logic                     i_SCK,
    input  logic                     i_RST,
    input  logic                     i_START,
    input  logic [CNT_W-1:0]         i_N_transmit,
    input  logic [WIDTH*DEPTH-1:0]   i_DATA,
    input  logic [DEPTH-1:0]         i_DC,
    output logic                     o_MOSI,
    output logic                     o_CS,
    output logic                     o_DC,
    output logic                     o_BUSY,
    output logic                     o_BYTE_DONE,
    output logic                     o_DONE,
    output logic                     o_REJECT
);

    localparam int WIDX_W = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;
    localparam int NCNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W  = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q;

    // Captured burst payload (datapath, not reset)
    logic [WIDTH-1:0]    words_q [DEPTH];
    logic [DEPTH-1:0]    dc_q;

    // Control counters
    logic [WIDX_W-1:0]   word_idx_q;
    logic [WIDX_W-1:0]   last_idx_q;
    logic [BIT_W-1:0]    bit_idx_q;
    logic [GAP_W-1:0]    gap_cnt_q;

    // Registered outputs
    logic                mosi_q;
    logic                cs_q;
    logic                dc_out_q;
    logic                busy_q;
    logic                byte_done_q;
    logic                done_q;
    logic                reject_q;

    // Next-state helpers
    logic [NCNT_W-1:0]   n_clamp_d;
    logic [WIDX_W-1:0]   last_idx_d;
    logic [WIDX_W-1:0]   word_idx_d;
    logic [BIT_W-1:0]    bit_idx_d;
    logic [GAP_W-1:0]    gap_cnt_d;
    logic [WIDTH-1:0]    cur_word;
    logic [WIDTH-1:0]    nxt_word;

    // Bit k of the shift order for a word (k = number of edges since the
    // word's first bit appeared).
    function automatic logic tx_bit(input logic [WIDTH-1:0] w,
                                    input logic [BIT_W-1:0] idx);
`ifdef MOSI_LSB_FIRST_EN
        return w[idx];
`else
        return w[BIT_LAST - idx];
`endif
    endfunction

    always_comb begin
        // Requests above DEPTH are silently clamped.
        n_clamp_d  = (i_N_transmit > DEPTH_CNT) ? NCNT_W'(DEPTH) : NCNT_W'(i_N_transmit);
        // Only meaningful when n_clamp_d > 0; the n == 0 case never uses it.
        last_idx_d = WIDX_W'(n_clamp_d - NCNT_W'(1));
        word_idx_d = word_idx_q + WIDX_W'(1);
        bit_idx_d  = bit_idx_q + BIT_W'(1);
        gap_cnt_d  = gap_cnt_q + GAP_W'(1);
        cur_word   = words_q[word_idx_q];
        nxt_word   = words_q[word_idx_d];
    end

    // Payload capture happens only on an accepted start; later changes on
    // i_DATA / i_DC are invisible to the burst.
    always_ff @(posedge i_SCK) begin
        if (state_q == IDLE && i_START) begin
            for (int k = 0; k < DEPTH; k++) begin
                words_q[k] <= i_DATA[k*WIDTH +: WIDTH];
            end
            dc_q <= i_DC;
        end
    end

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            state_q     <= IDLE;
            word_idx_q  <= '0;
            last_idx_q  <= '0;
            bit_idx_q   <= '0;
            gap_cnt_q   <= '0;
            mosi_q      <= 1'b0;
            cs_q        <= 1'b1;
            dc_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (i_START) begin
                        if (n_clamp_d == '0) begin
                            // Empty burst: report completion, never frame.
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= SHIFT;
                            busy_q     <= 1'b1;
                            cs_q       <= 1'b0;
                            dc_out_q   <= i_DC[0];
                            // First bit comes straight from the input port
                            // since words_q is being loaded on this same edge.
                            mosi_q     <= tx_bit(i_DATA[WIDTH-1:0], '0);
                            word_idx_q <= '0;
                            bit_idx_q  <= '0;
                            gap_cnt_q  <= '0;
                            last_idx_q <= last_idx_d;
                        end
                    end
                end

                SHIFT: begin
                    if (i_START) begin
                        reject_q <= 1'b1;
                    end
                    if (bit_idx_q != BIT_LAST) begin
                        bit_idx_q <= bit_idx_d;
                        mosi_q    <= tx_bit(cur_word, bit_idx_d);
                    end else if (word_idx_q == last_idx_q) begin
                        // Final word finished; o_DC keeps its last value.
                        state_q     <= IDLE;
                        cs_q        <= 1'b1;
                        mosi_q      <= 1'b0;
                        busy_q      <= 1'b0;
                        byte_done_q <= 1'b1;
                        done_q      <= 1'b1;
                        bit_idx_q   <= '0;
                        word_idx_q  <= '0;
                    end else begin
                        byte_done_q <= 1'b1;
                        word_idx_q  <= word_idx_d;
                        bit_idx_q   <= '0;
                        if (CS_GAP == 0) begin
                            // Back-to-back words under one continuous CS.
                            mosi_q   <= tx_bit(nxt_word, '0);
                            dc_out_q <= dc_q[word_idx_d];
                        end else begin
                            state_q   <= GAP;
                            cs_q      <= 1'b1;
                            mosi_q    <= 1'b0;
                            gap_cnt_q <= '0;
                        end
                    end
                end

                GAP: begin
                    if (i_START) begin
                        reject_q <= 1'b1;
                    end
                    // word_idx_q already points at the upcoming word here.
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q  <= SHIFT;
                        cs_q     <= 1'b0;
                        mosi_q   <= tx_bit(cur_word, '0);
                        dc_out_q <= dc_q[word_idx_q];
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_MOSI      = mosi_q;
    assign o_CS        = cs_q;
    assign o_DC        = dc_out_q;
    assign o_BUSY      = busy_q;
    assign o_BYTE_DONE = byte_done_q;
    assign o_DONE      = done_q;
    assign o_REJECT    = reject_q;

endmodule

// File: tb/tb_spi_mosi_burst_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_mosi_burst_tx
//
// Directed bench for spi_mosi_burst_tx. Instance "dut_a" uses the default
// parameters (CS_GAP=1); instance "dut_b" uses CS_GAP=0. Every output is
// sampled 1 time unit after the rising edge and compared against an expected
// cycle stream built from the word list, D/C flags, count and gap setting.
// Output vector order: {MOSI, CS, DC, BUSY, BYTE_DONE, DONE, REJECT}.
// -----------------------------------------------------------------------------
module tb_spi_mosi_burst_tx;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_a = 1'b0;
    logic           start_b = 1'b0;
    logic [CW-1:0]  n_tx = '0;
    logic [W*D-1:0] data = '0;
    logic [D-1:0]   dc = '0;

    logic mosi_a, cs_a, dc_a, busy_a, bd_a, done_a, rej_a;
    logic mosi_b, cs_b, dc_b, busy_b, bd_b, done_b, rej_b;

    int errors = 0;
    int checks = 0;

    int bd_cnt, cs_low_cnt, busy_cnt, done_idx, rej_cnt;

    logic [6:0] exq[$];
    logic [6:0] mq[$];

    always #5 clk = ~clk;

    spi_mosi_burst_tx #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .CS_GAP(1)) dut_a (
        .i_SCK(clk), .i_RST(rst), .i_START(start_a), .i_N_transmit(n_tx),
        .i_DATA(data), .i_DC(dc),
        .o_MOSI(mosi_a), .o_CS(cs_a), .o_DC(dc_a), .o_BUSY(busy_a),
        .o_BYTE_DONE(bd_a), .o_DONE(done_a), .o_REJECT(rej_a)
    );

    spi_mosi_burst_tx #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .CS_GAP(0)) dut_b (
        .i_SCK(clk), .i_RST(rst), .i_START(start_b), .i_N_transmit(n_tx),
        .i_DATA(data), .i_DC(dc),
        .o_MOSI(mosi_b), .o_CS(cs_b), .o_DC(dc_b), .o_BUSY(busy_b),
        .o_BYTE_DONE(bd_b), .o_DONE(done_b), .o_REJECT(rej_b)
    );

    function automatic logic [6:0] obs(input bit sel);
        if (sel) return {mosi_b, cs_b, dc_b, busy_b, bd_b, done_b, rej_b};
        return {mosi_a, cs_a, dc_a, busy_a, bd_a, done_a, rej_a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp, input logic [6:0] msk);
        checks++;
        assert ((got & msk) === (exp & msk)) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (mask %b)", tag, got & msk, exp & msk, msk);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present a request; the next rising edge samples it.
    task automatic arm(input bit sel, input int n, input logic [W*D-1:0] wd,
                       input logic [D-1:0] wdc);
        n_tx = n[CW-1:0];
        data = wd;
        dc   = wdc;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
    endtask

    // Idle cycles: CS high, nothing busy, no pulses (D/C not checked).
    task automatic idle(input bit sel, input int cycles, input string tag);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk($sformatf("%s_idle%0d", tag, i), obs(sel), 7'b0100000, 7'b1101111);
        end
    endtask

    // Performs the start edge, then checks every cycle up to and including the
    // done cycle. rej_at: cycle after which i_START is pulsed mid-burst.
    // rst_at: cycle after which reset is applied (burst aborted).
    task automatic run_burst(input bit sel, input string tag, input int n,
                             input int gap, input logic [W*D-1:0] wd,
                             input logic [D-1:0] wdc, input int rej_at,
                             input int rst_at);
        logic [6:0] o;
        logic       b;
        exq.delete();
        mq.delete();
        if (n == 0) begin
            exq.push_back(7'b0100010);
            mq.push_back(7'b1101111);
        end else begin
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < W; k++) begin
`ifdef MOSI_LSB_FIRST_EN
                    b = wd[w*W + k];
`else
                    b = wd[w*W + (W-1-k)];
`endif
                    exq.push_back({b, 1'b0, wdc[w], 1'b1,
                                   (gap == 0 && k == 0 && w > 0), 1'b0, 1'b0});
                    mq.push_back(7'b1111111);
                end
                if (w < n-1) begin
                    for (int g = 0; g < gap; g++) begin
                        exq.push_back({1'b0, 1'b1, 1'b0, 1'b1, (g == 0), 1'b0, 1'b0});
                        mq.push_back(7'b1101111);
                    end
                end
            end
            exq.push_back({1'b0, 1'b1, wdc[n-1], 1'b0, 1'b1, 1'b1, 1'b0});
            mq.push_back(7'b1111111);
        end
        if (rej_at >= 0 && rej_at + 1 < exq.size()) exq[rej_at+1][0] = 1'b1;

        bd_cnt = 0; cs_low_cnt = 0; busy_cnt = 0; done_idx = -1; rej_cnt = 0;

        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        // Scramble inputs after the start edge; the burst must not notice.
        data = ~wd;
        dc   = ~wdc;
        n_tx = '1;

        for (int c = 0; c < exq.size(); c++) begin
            o = obs(sel);
            chk($sformatf("%s[%0d]", tag, c), o, exq[c], mq[c]);
            if (!o[5]) cs_low_cnt++;
            if (o[3])  busy_cnt++;
            if (o[2])  bd_cnt++;
            if (o[1])  done_idx = c;
            if (o[0])  rej_cnt++;
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk($sformatf("%s_rst", tag), obs(sel), 7'b0100000, 7'b1111111);
                break;
            end
            if (c == exq.size() - 1) break;
            if (sel) start_b = (c == rej_at);
            else     start_a = (c == rej_at);
            tick();
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("reset_a", obs(1'b0), 7'b0100000, 7'b1111111);
        chk("reset_b", obs(1'b1), 7'b0100000, 7'b1111111);
        rst = 1'b0;
        idle(1'b0, 2, "post_rst");

        // 1: full 8-word burst, one CS-high cycle between words
        arm(1'b0, 8, 64'h7FBFDFEFF7FBFDFE, 8'hAA);
        run_burst(1'b0, "t1", 8, 1, 64'h7FBFDFEFF7FBFDFE, 8'hAA, -1, -1);
        chk_int("t1_busy_cycles", busy_cnt, 71);
        chk_int("t1_cs_low_cycles", cs_low_cnt, 64);
        chk_int("t1_byte_done", bd_cnt, 8);
        chk_int("t1_done_at", done_idx, 71);
        idle(1'b0, 3, "t1");

        // 2: CS_GAP=0, CS held low across four words
        arm(1'b1, 4, 64'h00000000C0300C03, 8'h0C);
        run_burst(1'b1, "t2", 4, 0, 64'h00000000C0300C03, 8'h0C, -1, -1);
        chk_int("t2_cs_low_cycles", cs_low_cnt, 32);
        chk_int("t2_busy_cycles", busy_cnt, 32);
        chk_int("t2_byte_done", bd_cnt, 4);
        chk_int("t2_done_at", done_idx, 32);
        idle(1'b1, 3, "t2");

        // 3: empty burst
        arm(1'b0, 0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        run_burst(1'b0, "t3", 0, 1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, -1, -1);
        chk_int("t3_cs_low_cycles", cs_low_cnt, 0);
        chk_int("t3_busy_cycles", busy_cnt, 0);
        chk_int("t3_done_at", done_idx, 0);
        idle(1'b0, 2, "t3");

        // 4: count clamped to DEPTH, start pulsed mid-burst is rejected
        arm(1'b0, 12, 64'h0123456789ABCDEF, 8'h5A);
        run_burst(1'b0, "t4", 8, 1, 64'h0123456789ABCDEF, 8'h5A, 20, -1);
        chk_int("t4_byte_done", bd_cnt, 8);
        chk_int("t4_done_at", done_idx, 71);
        chk_int("t4_reject", rej_cnt, 1);
        idle(1'b0, 2, "t4");

        // 5: restart in the done cycle -> one CS-high cycle between bursts
        arm(1'b0, 1, 64'h00000000000000A5, 8'h01);
        run_burst(1'b0, "t5a", 1, 1, 64'h00000000000000A5, 8'h01, -1, -1);
        chk_int("t5a_done_at", done_idx, 8);
        arm(1'b0, 2, 64'h0000000000000C03, 8'h02);
        run_burst(1'b0, "t5b", 2, 1, 64'h0000000000000C03, 8'h02, -1, -1);
        chk_int("t5b_done_at", done_idx, 17);
        chk_int("t5b_byte_done", bd_cnt, 2);
        idle(1'b0, 2, "t5");

        // 6: reset during word 3 aborts; a fresh burst then runs cleanly
        arm(1'b0, 8, 64'h7FBFDFEFF7FBFDFE, 8'hAA);
        run_burst(1'b0, "t6", 8, 1, 64'h7FBFDFEFF7FBFDFE, 8'hAA, -1, 31);
        chk_int("t6_no_done", done_idx, -1);
        idle(1'b0, 3, "t6");
        arm(1'b0, 3, 64'h0000000000C33C96, 8'h05);
        run_burst(1'b0, "t6b", 3, 1, 64'h0000000000C33C96, 8'h05, -1, -1);
        chk_int("t6b_done_at", done_idx, 26);
        chk_int("t6b_byte_done", bd_cnt, 3);
        idle(1'b0, 2, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
